// File: rtl/pri_dec_24.sv
// Registered 2-to-4 priority-code decoder: a small FIFO between two valid/ready
// ports, with saturating per-line delivery counters for debug and statistics.
module pri_dec_24 #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         in_code,
  output logic               in_ready,
  output logic               out_valid,
  output logic [3:0]         out_onehot,
  input  logic               out_ready,
  input  logic               clr_cnt,
  output logic [4*CNT_W-1:0] hit_cnt,
  output logic [3:0]         sat
);

  // Handshake rule, both ports: a transfer happens at a rising edge exactly when
  // valid && ready; valid never waits on ready, and a presented head stays stable
  // until it is taken.

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] OCC_FULL = (PW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_NEAR = {{(CNT_W-1){1'b1}}, 1'b0};

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] PARTIAL = 2'd1;
  localparam logic [1:0] FULL    = 2'd2;

  logic [1:0]       mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      occ;
  logic [PW:0]      occ_nxt;
  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic             ready_q;
  logic             push;
  logic             pop;
  logic [1:0]       head_code;
  logic [CNT_W-1:0] cnt [4];

  assign head_code  = mem[rd_ptr];
  assign in_ready   = ready_q && (state != FULL);
  assign out_valid  = (state != IDLE);
  assign out_onehot = out_valid ? (4'b1000 >> head_code) : 4'b0000;
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;

  always_comb begin
    occ_nxt = occ;
    case ({push, pop})
      2'b10:   occ_nxt = occ + 1'b1;
      2'b01:   occ_nxt = occ - 1'b1;
      default: occ_nxt = occ;
    endcase
    state_nxt = PARTIAL;
    if (occ_nxt == '0)
      state_nxt = IDLE;
    else if (occ_nxt == OCC_FULL)
      state_nxt = FULL;
  end

  // in_ready stays low through reset and opens on the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      occ     <= '0;
      state   <= IDLE;
    end else begin
      ready_q <= 1'b1;
      occ     <= occ_nxt;
      state   <= state_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_code;
  end

  // sat latches as soon as a counter reaches all-ones; clear beats a delivery.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      sat <= 4'b0000;
    end else if (clr_cnt) begin
      for (int k = 0; k < 4; k++) cnt[k] <= '0;
      sat <= 4'b0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (pop && out_onehot[k]) begin
          if (cnt[k] != CNT_MAX) begin
            cnt[k] <= cnt[k] + 1'b1;
            if (cnt[k] == CNT_NEAR) sat[k] <= 1'b1;
          end else begin
            sat[k] <= 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    hit_cnt = '0;
    for (int k = 0; k < 4; k++) hit_cnt[k*CNT_W +: CNT_W] = cnt[k];
  end

endmodule
